mult_accumulate_stage: RTL and testbench
========================================

// Module: mult_accumulate_stage
// PURPOSE
//  Downstream consumer of the 8x8 signed multiplier product (16-bit signed).
//  Registers each product offered over a valid/ready handshake and adds it into a signed accumulator.
//  On a product flagged last, it presents the group sum, term count and overflow flag on a held output handshake.
//  Forms the MAC back-end of the multiplier datapath.
// PARAMETERS
//  ACC_W     24  accumulator/output width in bits, signed; legal range 16..32
//  SATURATE  0   0 = two's-complement wrap on overflow; 1 = clamp to max/min representable
//  CNT_W     8   term-counter width; counter saturates at 2^CNT_W-1
// PORTS
//  clk        in   1       clock, all state updates on rising edge
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       product valid
//  in_ready   out  1       stage can accept a product this cycle
//  in_prod    in   16      signed product (multiplier OUT)
//  in_last    in   1       this product closes the accumulation group
//  out_valid  out  1       group result valid
//  out_ready  in   1       consumer accepts the result
//  out_sum    out  ACC_W   signed group sum
//  out_count  out  CNT_W   number of products in the group
//  out_ovf    out  1       sticky: overflow occurred at least once in the group
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high (rst). All outputs are registered.
//  - Reset state: IDLE, acc=0, cnt=0, ovf=0.
//    Output reset values: out_valid=0, out_sum=0, out_count=0, out_ovf=0, in_ready=1.
//  - Reset asserted mid-group or in HOLD discards all partial/held state the same cycle; there is no output.
//  - FSM states:
//      IDLE  : no terms accumulated yet.
//      ACCUM : 1 or more terms accumulated, last not yet seen.
//      HOLD  : result presented, waiting for out_ready.
//  - in_ready = (state != HOLD). Accept = in_valid & in_ready. in_prod/in_last are ignored when not accepted.
//  - On accept:
//      ext  = sign-extend(in_prod) to ACC_W
//      sum  = acc + ext
//      ov   = (acc[MSB] == ext[MSB]) & (sum[MSB] != acc[MSB])
//      acc <= ov ? (SATURATE ? (acc[MSB] ? MIN : MAX) : sum) : sum
//      ovf <= ovf | ov
//      cnt <= cnt + 1, saturating at all-ones
//  - Accept with in_last=0: IDLE->ACCUM, ACCUM->ACCUM.
//  - Accept with in_last=1: from IDLE or ACCUM go to HOLD.
//    Next cycle: out_valid=1, out_sum=new acc, out_count=new cnt, out_ovf=new ovf.
//    Latency: last accepted at edge N -> out_valid high after edge N.
//  - HOLD: out_valid, out_sum, out_count and out_ovf are held stable; in_ready=0.
//    While out_ready=0: no change.
//    On out_valid & out_ready: out_valid<=0, acc/cnt/ovf<=0, state<=IDLE; in_ready returns 1 the following cycle (no bypass).
//  - out_sum, out_count and out_ovf keep their last presented values after handoff until the next group completes.
//  - SATURATE=1: the clamped value is the new base; later terms may pull it back in range; ovf stays set.
//  - Count saturation does not affect the sum or ovf.
//  - Back-to-back groups: minimum 2-cycle spacing between results (1 HOLD cycle + 1 IDLE cycle).
// TESTING
//  1. Products 100, -50, 7 (last on 7), out_ready=1 -> out_sum=57, out_count=3, out_ovf=0; out_valid one cycle after last accept.
//  2. ACC_W=16, SATURATE=0: 16384 x2 (last on 2nd) -> out_sum=-32768, out_ovf=1.
//     Same stimulus with SATURATE=1 -> out_sum=32767, out_ovf=1.
//  3. Single product -16256 with last=1 -> out_sum=-16256, out_count=1; state goes IDLE->HOLD directly.
//  4. Backpressure: hold out_ready=0 for 5 cycles in HOLD while in_valid=1 ->
//     in_ready=0 and outputs stable all 5 cycles; out_ready=1 -> handoff, in_ready=1 next cycle.
//  5. rst pulsed after 2 of 3 products ->
//     no out_valid; a new group of 5 (last) -> out_sum=5, out_count=1.
//  6. CNT_W=2: five products of 1, last on 5th -> out_count=3 (saturated), out_sum=5.

Source files
------------

// File: rtl/mult_accumulate_stage_if.sv
// Handshake bundle between the multiplier product stream and the MAC back-end.
// Product side: in_valid/in_ready with in_prod/in_last.
// Result side: out_valid/out_ready with out_sum/out_count/out_ovf.
interface mult_accumulate_stage_if #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [15:0]      in_prod;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0]        out_count;
  logic                    out_ovf;

  // Producer of products / consumer of results
  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  // The accumulate stage itself
  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/mult_accumulate_stage.sv
// MAC back-end: accumulates signed 16-bit products into a signed ACC_W
// accumulator and presents {sum, count, overflow} per group closed by in_last.
// ACC_W legal range is 16..32; the interface must be built with the same
// ACC_W/CNT_W as this module.
module mult_accumulate_stage #(
  parameter int ACC_W    = 24,
  parameter bit SATURATE = 1'b0,
  parameter int CNT_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  mult_accumulate_stage_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  typedef struct packed {
    logic signed [ACC_W-1:0] sum;
    logic [CNT_W-1:0]        cnt;
    logic                    ovf;
  } res_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;
  res_t                    res_q, res_d;
  logic                    vld_q, vld_d;
  logic                    rdy_q;

  logic signed [ACC_W-1:0] ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] acc_nxt;
  logic [CNT_W-1:0]        cnt_nxt;
  logic                    ov;
  logic                    accept;

  // rdy_q mirrors (state_q != HOLD) but comes straight from a flop
  assign accept = bus.in_valid & rdy_q;

  // Term datapath: sign-extend, add, detect signed overflow, optional clamp
  always_comb begin
    ext     = ACC_W'(bus.in_prod);
    sum     = acc_q + ext;
    ov      = (acc_q[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
    acc_nxt = sum;
    if (ov && SATURATE)
      acc_nxt = acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
    cnt_nxt = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // Next-state and next-register logic for the group FSM
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    res_d   = res_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_d = acc_nxt;
          cnt_d = cnt_nxt;
          ovf_d = ovf_q | ov;
          if (bus.in_last) begin
            state_d = HOLD;
            vld_d   = 1'b1;
            res_d   = '{sum: acc_nxt, cnt: cnt_nxt, ovf: ovf_q | ov};
          end else begin
            state_d = ACCUM;
          end
        end
      end
      HOLD: begin
        // Result stays frozen until taken; accumulator restarts afterwards
        if (bus.out_ready) begin
          state_d = IDLE;
          vld_d   = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any partial or held group
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      res_q   <= '0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      res_q   <= res_d;
      vld_q   <= vld_d;
      rdy_q   <= (state_d != HOLD);
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = vld_q;
  assign bus.out_sum   = res_q.sum;
  assign bus.out_count = res_q.cnt;
  assign bus.out_ovf   = res_q.ovf;

endmodule

// File: tb/tb_mult_accumulate_stage.sv
// Bench for mult_accumulate_stage: three configurations share one stimulus
// stream (24-bit wrap, 16-bit wrap, 16-bit saturate with 2-bit counter) and
// are compared against an integer-arithmetic group model.
module tb_mult_accumulate_stage;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic signed [15:0] in_prod;
  logic               in_last;
  logic               out_ready;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mult_accumulate_stage_if #(.ACC_W(24), .CNT_W(8)) if_a ();
  mult_accumulate_stage_if #(.ACC_W(16), .CNT_W(8)) if_w ();
  mult_accumulate_stage_if #(.ACC_W(16), .CNT_W(2)) if_s ();

  assign if_a.in_valid = in_valid;  assign if_a.in_prod = in_prod;
  assign if_a.in_last  = in_last;   assign if_a.out_ready = out_ready;
  assign if_w.in_valid = in_valid;  assign if_w.in_prod = in_prod;
  assign if_w.in_last  = in_last;   assign if_w.out_ready = out_ready;
  assign if_s.in_valid = in_valid;  assign if_s.in_prod = in_prod;
  assign if_s.in_last  = in_last;   assign if_s.out_ready = out_ready;

  mult_accumulate_stage #(.ACC_W(24), .SATURATE(1'b0), .CNT_W(8))
    dut_a (.clk(clk), .rst(rst), .bus(if_a));
  mult_accumulate_stage #(.ACC_W(16), .SATURATE(1'b0), .CNT_W(8))
    dut_w (.clk(clk), .rst(rst), .bus(if_w));
  mult_accumulate_stage #(.ACC_W(16), .SATURATE(1'b1), .CNT_W(2))
    dut_s (.clk(clk), .rst(rst), .bus(if_s));

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Group result from plain integer arithmetic: out-of-range partial sums
  // flag overflow and are either wrapped by 2^w or clamped to the range.
  function automatic void ref_group(input int ps[$], input int w, input bit sat,
                                    input int cw, output longint s,
                                    output longint c, output longint o);
    longint mx, mn, t;
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -(longint'(1) << (w - 1));
    s = 0;
    o = 0;
    foreach (ps[i]) begin
      t = s + ps[i];
      if (t > mx || t < mn) begin
        o = 1;
        if (sat) t = (t > mx) ? mx : mn;
        else     t = (t > mx) ? t - (mx - mn + 1) : t + (mx - mn + 1);
      end
      s = t;
    end
    c = (ps.size() > (2 ** cw - 1)) ? longint'(2 ** cw - 1) : longint'(ps.size());
  endfunction

  task automatic check_res(input string tag, input int ps[$]);
    longint s, c, o;
    ref_group(ps, 24, 1'b0, 8, s, c, o);
    chk({tag, "_a_sum"}, longint'($signed(if_a.out_sum)), s);
    chk({tag, "_a_cnt"}, longint'(if_a.out_count), c);
    chk({tag, "_a_ovf"}, longint'(if_a.out_ovf), o);
    ref_group(ps, 16, 1'b0, 8, s, c, o);
    chk({tag, "_w_sum"}, longint'($signed(if_w.out_sum)), s);
    chk({tag, "_w_cnt"}, longint'(if_w.out_count), c);
    chk({tag, "_w_ovf"}, longint'(if_w.out_ovf), o);
    ref_group(ps, 16, 1'b1, 2, s, c, o);
    chk({tag, "_s_sum"}, longint'($signed(if_s.out_sum)), s);
    chk({tag, "_s_cnt"}, longint'(if_s.out_count), c);
    chk({tag, "_s_ovf"}, longint'(if_s.out_ovf), o);
  endtask

  // Offer one product after `gap` idle cycles of junk; returns after accept.
  task automatic put(input int p, input bit last, input int gap);
    int t;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_prod  = 16'($urandom);
      in_last  = 1'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_prod  = 16'(p);
    in_last  = last;
    t = 0;
    while (!if_a.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t == 50) chk("ready_timeout", 0, 1);
    chk("ov_early", longint'(if_a.out_valid), 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Check the result one cycle after the last accept, stall, then hand off.
  task automatic drain(input string tag, input int ps[$], input int stall);
    longint held;
    @(negedge clk);
    chk({tag, "_lat"}, longint'(if_a.out_valid), 1);
    check_res(tag, ps);
    held = longint'($signed(if_a.out_sum));
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      in_prod  = 16'($urandom);
      in_last  = 1'($urandom);
      @(negedge clk);
      chk({tag, "_bp_vld"}, longint'(if_a.out_valid), 1);
      chk({tag, "_bp_rdy"}, longint'(if_a.in_ready), 0);
      chk({tag, "_bp_sum"}, longint'($signed(if_a.out_sum)), held);
    end
    // junk stays valid across the handoff edge: it must not be taken
    in_valid  = 1'b1;
    in_last   = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    @(negedge clk);
    chk({tag, "_ho_vld"}, longint'(if_a.out_valid), 0);
    chk({tag, "_ho_rdy"}, longint'(if_a.in_ready), 1);
    chk({tag, "_ho_sum"}, longint'($signed(if_a.out_sum)), held);
  endtask

  task automatic run_group(input string tag, input int ps[$], input int stall,
                           input bit gaps);
    foreach (ps[i])
      put(ps[i], (i == ps.size() - 1), gaps ? $urandom_range(0, 2) : 0);
    drain(tag, ps, stall);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got 0 expected 1");
    $fatal(1, "watchdog");
  end

  initial begin
    int ps[$];
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_prod   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_vld", longint'(if_a.out_valid), 0);
    chk("rst_rdy", longint'(if_a.in_ready), 1);
    chk("rst_sum", longint'($signed(if_a.out_sum)), 0);
    chk("rst_cnt", longint'(if_a.out_count), 0);
    chk("rst_ovf", longint'(if_a.out_ovf), 0);
    rst = 1'b0;

    ps = '{100, -50, 7};
    run_group("t1", ps, 0, 1'b0);
    chk("t1_const_sum", longint'($signed(if_a.out_sum)), 57);
    chk("t1_const_cnt", longint'(if_a.out_count), 3);

    ps = '{16384, 16384};
    run_group("t2", ps, 0, 1'b0);
    chk("t2_wrap_sum", longint'($signed(if_w.out_sum)), -32768);
    chk("t2_wrap_ovf", longint'(if_w.out_ovf), 1);
    chk("t2_sat_sum", longint'($signed(if_s.out_sum)), 32767);
    chk("t2_sat_ovf", longint'(if_s.out_ovf), 1);

    ps = '{-16256};
    run_group("t3", ps, 0, 1'b0);
    chk("t3_const_sum", longint'($signed(if_a.out_sum)), -16256);

    ps = '{300, -20};
    run_group("t4", ps, 5, 1'b0);

    // reset mid-group: partial terms vanish, no result appears
    put(10, 1'b0, 0);
    put(20, 1'b0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("t5_vld", longint'(if_a.out_valid), 0);
      chk("t5_rdy", longint'(if_a.in_ready), 1);
    end
    ps = '{5};
    run_group("t5", ps, 0, 1'b0);
    chk("t5_const_sum", longint'($signed(if_a.out_sum)), 5);

    ps = '{1, 1, 1, 1, 1};
    run_group("t6", ps, 1, 1'b0);
    chk("t6_const_cnt", longint'(if_s.out_count), 3);
    chk("t6_const_sum", longint'($signed(if_s.out_sum)), 5);

    // saturated value is the new base; later terms pull it back
    ps = '{30000, 30000, -30000};
    run_group("t7", ps, 0, 1'b0);

    for (int g = 0; g < 40; g++) begin
      int n;
      ps.delete();
      n = $urandom_range(1, 7);
      for (int k = 0; k < n; k++)
        ps.push_back(($urandom_range(0, 3) == 0) ?
                     (($urandom_range(0, 1) == 1) ? 32767 - int'($urandom_range(0, 99))
                                                  : -32768 + int'($urandom_range(0, 99)))
                     : int'($signed(16'($urandom))));
      run_group("rnd", ps, $urandom_range(0, 3), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
